// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the writeback-bus round-robin arbiter.
package wb_arb_pkg;

  localparam int unsigned NREQ  = 5;
  localparam int unsigned SEL_W = 3;

  localparam logic [SEL_W-1:0] SEL_NONE = 3'b000;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StGrant = 1'b1
  } arb_state_e;

  // (a + b) mod NREQ for a, b already in 0..NREQ-1.
  function automatic logic [SEL_W-1:0] add_mod(input logic [SEL_W-1:0] a,
                                               input logic [SEL_W-1:0] b);
    logic [SEL_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= (SEL_W+1)'(NREQ)) s = s - (SEL_W+1)'(NREQ);
    return s[SEL_W-1:0];
  endfunction

endpackage

// File: rtl/wb_mux_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping mod NREQ.
module rr_pick
  import wb_arb_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx,
  output logic [NREQ-1:0]  onehot
);

  logic [SEL_W-1:0] cand;

  // Scan from the farthest offset down so the nearest hit is written last.
  always_comb begin
    any  = 1'b0;
    idx  = SEL_NONE;
    cand = SEL_NONE;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = add_mod(ptr, SEL_W'(k));
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    onehot = any ? (NREQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/wb_mux_arbiter.sv
// Round-robin arbiter for the 5:1 writeback result mux with valid/ready handshake
// towards the register file and a watchdog that force-releases a stalled grant.
module wb_mux_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic             wb_ready,
  output logic [SEL_W-1:0] sel,
  output logic [NREQ-1:0]  grant,
  output logic             wb_valid,
  output logic             xfer_done,
  output logic             timeout_err
);

  arb_state_e       state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [7:0]       cnt_inc;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic             valid_q, valid_d;
  logic             xfer_q, xfer_d;
  logic             tout_q, tout_d;

  logic             in_grant, handshake, abort, expire;
  logic [SEL_W-1:0] pick_ptr;
  logic             pick_any;
  logic [SEL_W-1:0] pick_idx;
  logic [NREQ-1:0]  pick_onehot;

  // In GRANT the pick is the back-to-back one, so it searches from the post-transfer ptr.
  assign in_grant = (state_q == StGrant);
  assign pick_ptr = in_grant ? add_mod(sel_q, SEL_W'(1)) : ptr_q;
  assign cnt_inc  = cnt_q + 8'd1;

  assign handshake = in_grant & wb_ready;
  assign abort     = in_grant & ~wb_ready & ~req[sel_q];
  assign expire    = in_grant & ~wb_ready & req[sel_q] & (cnt_inc == 8'(TIMEOUT));

  rr_pick u_pick (
    .req    (req),
    .ptr    (pick_ptr),
    .any    (pick_any),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= SEL_NONE;
      cnt_q   <= '0;
      sel_q   <= SEL_NONE;
      grant_q <= '0;
      valid_q <= 1'b0;
      xfer_q  <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      xfer_q  <= xfer_d;
      tout_q  <= tout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (pick_any) state_d = StGrant;
      end
      StGrant: begin
        if (handshake) begin
          ptr_d   = pick_ptr;
          cnt_d   = '0;
          state_d = pick_any ? StGrant : StIdle;
        end else if (abort) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else if (expire) begin
          ptr_d   = pick_ptr;
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    sel_d   = sel_q;
    grant_d = grant_q;
    valid_d = valid_q;
    xfer_d  = 1'b0;
    tout_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        sel_d   = pick_any ? pick_idx : SEL_NONE;
        grant_d = pick_onehot;
        valid_d = pick_any;
      end
      StGrant: begin
        if (handshake) begin
          xfer_d  = 1'b1;
          sel_d   = pick_any ? pick_idx : SEL_NONE;
          grant_d = pick_onehot;
          valid_d = pick_any;
        end else if (abort || expire) begin
          tout_d  = expire;
          sel_d   = SEL_NONE;
          grant_d = '0;
          valid_d = 1'b0;
        end
      end
      default: begin
        sel_d   = SEL_NONE;
        grant_d = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  assign sel         = sel_q;
  assign grant       = grant_q;
  assign wb_valid    = valid_q;
  assign xfer_done   = xfer_q;
  assign timeout_err = tout_q;

endmodule

// File: tb/tb_wb_mux_arbiter.sv
// Directed bench for wb_mux_arbiter: reset, single request, round robin, abort,
// watchdog timeout and asynchronous reset during a handshake.
module tb_wb_mux_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] req = 5'b0;
  logic       wb_ready = 1'b0;
  logic [2:0] sel;
  logic [4:0] grant;
  logic       wb_valid;
  logic       xfer_done;
  logic       timeout_err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  wb_mux_arbiter #(.TIMEOUT(15)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .wb_ready    (wb_ready),
    .sel         (sel),
    .grant       (grant),
    .wb_valid    (wb_valid),
    .xfer_done   (xfer_done),
    .timeout_err (timeout_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [4:0] g, input logic [2:0] s,
                         input logic v, input logic xd, input logic te);
    chk({tag, ".grant"}, {3'b0, grant}, {3'b0, g});
    chk({tag, ".sel"}, {5'b0, sel}, {5'b0, s});
    chk({tag, ".wb_valid"}, {7'b0, wb_valid}, {7'b0, v});
    chk({tag, ".xfer_done"}, {7'b0, xfer_done}, {7'b0, xd});
    chk({tag, ".timeout_err"}, {7'b0, timeout_err}, {7'b0, te});
  endtask

  task automatic do_reset();
    req      = 5'b0;
    wb_ready = 1'b0;
    rst_n    = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset and idle
    #2;
    chk_out("reset", 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_out("idle", 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0);
    end

    // Single request from source 3, accepted on the second grant cycle
    req = 5'b01000;
    tick();
    chk_out("single.g1", 5'b01000, 3'd3, 1'b1, 1'b0, 1'b0);
    tick();
    chk_out("single.g2", 5'b01000, 3'd3, 1'b1, 1'b0, 1'b0);
    wb_ready = 1'b1;
    req      = 5'b00000;
    tick();
    chk_out("single.done", 5'b00000, 3'd0, 1'b0, 1'b1, 1'b0);
    wb_ready = 1'b0;
    tick();
    chk_out("single.after", 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0);
    // ptr is now 4: with sources 0 and 4 both requesting, 4 wins
    req = 5'b10001;
    tick();
    chk_out("single.ptr4", 5'b10000, 3'd4, 1'b1, 1'b0, 1'b0);

    // Round robin, all requesting, always ready
    do_reset();
    req      = 5'b11111;
    wb_ready = 1'b1;
    tick();
    chk_out("rr.0", 5'b00001, 3'd0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_out("rr.1", 5'b00010, 3'd1, 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("rr.2", 5'b00100, 3'd2, 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("rr.3", 5'b01000, 3'd3, 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("rr.4", 5'b10000, 3'd4, 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("rr.wrap", 5'b00001, 3'd0, 1'b1, 1'b1, 1'b0);

    // Abort: source 2 drops its request while waiting
    do_reset();
    req = 5'b00100;
    tick();
    chk_out("abort.grant", 5'b00100, 3'd2, 1'b1, 1'b0, 1'b0);
    req = 5'b00000;
    tick();
    chk_out("abort.idle", 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0);
    req = 5'b00101;
    tick();
    chk_out("abort.repick", 5'b00001, 3'd0, 1'b1, 1'b0, 1'b0);

    // Watchdog: source 4 never gets ready
    do_reset();
    req = 5'b10000;
    tick();
    chk_out("tmo.grant", 5'b10000, 3'd4, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) begin
      tick();
      chk_out("tmo.wait", 5'b10000, 3'd4, 1'b1, 1'b0, 1'b0);
    end
    req = 5'b10001;
    tick();
    chk_out("tmo.fire", 5'b00000, 3'd0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_out("tmo.repick", 5'b00001, 3'd0, 1'b1, 1'b0, 1'b0);

    // Async reset lands just before a handshake edge
    do_reset();
    req = 5'b00010;
    tick();
    chk_out("arst.grant", 5'b00010, 3'd1, 1'b1, 1'b0, 1'b0);
    wb_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("arst.now", 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("arst.edge", 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0);
    rst_n    = 1'b1;
    req      = 5'b11111;
    wb_ready = 1'b0;
    tick();
    chk_out("arst.restart", 5'b00001, 3'd0, 1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
